// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory access controller: IDLE -> ACCESS -> DONE, min 2 cycles from mio_en to done.
// Optional access timeout with sticky err flag when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_mar,
  input  logic [15:0] mar_in,
  input  logic        ld_mdr,
  input  logic [15:0] mdr_in,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mdr_out,
  output logic        busy,
  output logic        done
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("WAIT_MAX must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] mar, mdr;
  logic        rw_q;
  logic        start;
  logic        timeout;

  assign start = (state == ST_IDLE) && mio_en;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] wait_cnt;

  // mem_ready wins over a timeout landing in the same cycle
  assign timeout = (state == ST_ACCESS) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else if (start) begin
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else if (state == ST_ACCESS && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (mio_en) state_nxt = ST_ACCESS;
      ST_ACCESS: if (mem_ready || timeout) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Loads happen only in IDLE, so an access launched alongside them sees the new values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mar  <= 16'h0000;
      mdr  <= 16'h0000;
      rw_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (ld_mar) mar  <= mar_in;
      if (ld_mdr) mdr  <= mdr_in;
      if (mio_en) rw_q <= r_w;
    end else if (state == ST_ACCESS && mem_ready && !rw_q) begin
      mdr <= mem_rdata;
    end
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign mdr_out   = mdr;
  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = (state == ST_ACCESS) && rw_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized checks of mem_access_ctrl against a transaction-level MAR/MDR model.
module tb_mem_access_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int WMAX = 4;
`else
  localparam int WMAX = 15;
`endif
  localparam int WRAND = (WMAX - 1 < 6) ? WMAX - 1 : 6;
  localparam int W5    = (WMAX > 5) ? 5 : WMAX - 1;

  logic        clk;
  logic        reset_n;
  logic        ld_mar, ld_mdr, mio_en, r_w, mem_ready;
  logic [15:0] mar_in, mdr_in, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, mdr_out;
  logic        mem_en, mem_we, busy, done;
`ifdef MEM_TIMEOUT_EN
  logic        err;
`endif

  mem_access_ctrl #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_mar(ld_mar), .mar_in(mar_in), .ld_mdr(ld_mdr), .mdr_in(mdr_in),
    .mio_en(mio_en), .r_w(r_w), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mdr_out(mdr_out), .busy(busy), .done(done)
`ifdef MEM_TIMEOUT_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_mar, m_mdr;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; mem_ready = 0;
  endtask

  // One full access: launch in IDLE, hold mem_ready low for 'waits' ACCESS cycles, then complete.
  task automatic access(input bit la, input logic [15:0] a, input bit ld, input logic [15:0] d,
                        input bit rw, input int waits, input logic [15:0] rd);
    ld_mar = la; mar_in = a; ld_mdr = ld; mdr_in = d; mio_en = 1; r_w = rw; mem_ready = 0;
    tick();
    if (la) m_mar = a;
    if (ld) m_mdr = d;
    ld_mar = 1; mar_in = 16'h0001; ld_mdr = 1; mdr_in = ~d; mio_en = 0; r_w = ~rw;
    for (int i = 0; i <= waits; i++) begin
      chk1("acc_mem_en", mem_en, 1'b1);
      chk1("acc_mem_we", mem_we, rw);
      chk16("acc_addr", mem_addr, m_mar);
      chk16("acc_wdata", mem_wdata, m_mdr);
      chk1("acc_busy", busy, 1'b1);
      chk1("acc_done", done, 1'b0);
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rd : 16'($urandom);
      tick();
    end
    if (!rw) m_mdr = rd;
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b1);
    chk1("done_mem_en", mem_en, 1'b0);
    chk1("done_mem_we", mem_we, 1'b0);
    chk16("done_mdr", mdr_out, m_mdr);
`ifdef MEM_TIMEOUT_EN
    chk1("done_err", err, 1'b0);
`endif
    quiet();
    tick();
    chk1("post_done", done, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk16("post_addr", mem_addr, m_mar);
    chk16("post_mdr", mdr_out, m_mdr);
  endtask

  initial begin
    int npulse;
    int last;
    quiet();
    reset_n = 0; mar_in = 0; mdr_in = 0; mem_rdata = 0;
    m_mar = 16'h0000; m_mdr = 16'h0000;
    #12;
    chk16("rst_addr", mem_addr, 16'h0000);
    chk16("rst_mdr", mdr_out, 16'h0000);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
`ifdef MEM_TIMEOUT_EN
    chk1("rst_err", err, 1'b0);
`endif
    tick();
    reset_n = 1;
    mem_ready = 1;
    tick();
    tick();
    chk1("no_spont_access", busy, 1'b0);
    mem_ready = 0;

    // Read example, write with simultaneous loads, wait-state access
    access(1, 16'h3000, 0, 16'h0000, 0, 0, 16'hBEEF);
    chk16("read_mdr", mdr_out, 16'hBEEF);
    access(1, 16'hFE00, 1, 16'h1234, 1, 0, 16'($urandom));
    chk16("write_mdr_kept", mdr_out, 16'h1234);
    access(1, 16'h4444, 0, 16'h0000, 0, W5, 16'h5A5A);
    chk16("wait_addr_kept", mem_addr, 16'h4444);

    // Randomized traffic with idle-cycle loads and stray mem_ready
    for (int n = 0; n < 12; n++) begin
      logic [15:0] ia, id;
      bit il, idl;
      il = 1'($urandom); idl = 1'($urandom); ia = 16'($urandom); id = 16'($urandom);
      ld_mar = il; mar_in = ia; ld_mdr = idl; mdr_in = id;
      mio_en = 0; mem_ready = 1; mem_rdata = 16'($urandom);
      tick();
      if (il) m_mar = ia;
      if (idl) m_mdr = id;
      quiet();
      chk1("idle_busy", busy, 1'b0);
      chk16("idle_addr", mem_addr, m_mar);
      chk16("idle_mdr", mdr_out, m_mdr);
      access(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
             1'($urandom), int'($urandom_range(0, WRAND)), 16'($urandom));
    end

    // Back-to-back: mio_en held for 9 cycles, ready always high
    npulse = 0; last = -1;
    mio_en = 1; r_w = 1; mem_ready = 1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk1("b2b_done", done, (t % 3) == 2);
      if (done) begin
        if (last >= 0) chk16("b2b_spacing", 16'(t - last), 16'd3);
        last = t;
        npulse++;
      end
    end
    quiet();
    chk16("b2b_count", 16'(npulse), 16'd3);
    tick();
    chk1("b2b_idle", busy, 1'b0);
    chk16("b2b_mdr", mdr_out, m_mdr);

    // Reset mid-access
    ld_mar = 1; mar_in = 16'h5555; ld_mdr = 1; mdr_in = 16'h6666; mio_en = 1; r_w = 0;
    tick();
    quiet();
    tick();
    chk1("mid_mem_en", mem_en, 1'b1);
    reset_n = 0;
    #1;
    m_mar = 16'h0000; m_mdr = 16'h0000;
    chk1("arst_mem_en", mem_en, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk16("arst_addr", mem_addr, m_mar);
    chk16("arst_mdr", mdr_out, m_mdr);
    mem_ready = 1;
    tick();
    reset_n = 1;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk1("arst_no_done", done, 1'b0);
      chk1("arst_no_busy", busy, 1'b0);
    end
    quiet();

`ifdef MEM_TIMEOUT_EN
    // Timeout: ready never arrives
    ld_mdr = 1; mdr_in = 16'hA5A5; mio_en = 1; r_w = 0; mem_ready = 0;
    tick();
    m_mdr = 16'hA5A5;
    quiet();
    for (int i = 0; i < WMAX; i++) begin
      chk1("to_mem_en", mem_en, 1'b1);
      chk1("to_err_low", err, 1'b0);
      mem_rdata = 16'($urandom);
      tick();
    end
    chk1("to_done", done, 1'b1);
    chk1("to_err", err, 1'b1);
    chk16("to_mdr", mdr_out, m_mdr);
    tick();
    chk1("to_idle", busy, 1'b0);
    chk1("to_err_sticky", err, 1'b1);
    mio_en = 1; r_w = 1;
    tick();
    chk1("to_err_clear", err, 1'b0);
    quiet();
    mem_ready = 1;
    tick();
    chk1("to_next_done", done, 1'b1);
    quiet();
    tick();
    // Ready on the last allowed cycle completes normally
    access(0, 16'h0000, 0, 16'h0000, 0, WMAX - 1, 16'h0F0F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum number of ACCESS cycles without mem_ready before timeout; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ld_mar  input  1  when high in IDLE, load MAR from mar_in.
REQ-005 mar_in  input  16  address from the upstream 16-bit address select mux.
REQ-006 ld_mdr  input  1  when high in IDLE, load MDR from mdr_in.
REQ-007 mdr_in  input  16  write data from the datapath bus.
REQ-008 mio_en  input  1  when high in IDLE, start one memory access.
REQ-009 r_w  input  1  access type, sampled with mio_en: 1 = write, 0 = read.
REQ-010 mem_rdata  input  16  read data from memory; valid when mem_ready is high.
REQ-011 mem_ready  input  1  memory completion for the current access.
REQ-012 mem_addr  output  16  current MAR contents.
REQ-013 mem_wdata  output  16  current MDR contents.
REQ-014 mem_en  output  1  memory request; high only in ACCESS.
REQ-015 mem_we  output  1  write strobe; equals the latched r_w while in ACCESS, 0 otherwise.
REQ-016 mdr_out  output  16  MDR contents to the datapath.
REQ-017 busy  output  1  high in ACCESS and DONE.
REQ-018 done  output  1  one-cycle completion pulse; high only in DONE.
REQ-019 err  output  1  timeout flag; exists only when MEM_TIMEOUT_EN is defined.

Function
REQ-020 The FSM has three states: IDLE, ACCESS and DONE; all outputs are registered or decoded from state only.
REQ-021 In IDLE, ld_mar/ld_mdr update MAR/MDR at the clock edge; mio_en=1 latches r_w and moves the FSM to ACCESS.
REQ-022 If ld_mar, ld_mdr and mio_en are all high in the same cycle, the access uses the newly loaded MAR/MDR values.
REQ-023 In ACCESS, mem_ready=1 moves the FSM to DONE; on a read, MDR is loaded from mem_rdata at the same edge.
REQ-024 In DONE, done=1 for exactly one cycle; the FSM then returns to IDLE unconditionally.
REQ-025 Minimum latency: mio_en at edge N, mem_en high in cycle N+1, done high in cycle N+2 when mem_ready=1 in the first ACCESS cycle.
REQ-026 While busy, ld_mar, ld_mdr, mio_en and r_w are ignored; MAR, MDR and the latched r_w are stable.
REQ-027 A write leaves MDR unchanged; mem_rdata is ignored outside ACCESS and on writes.
REQ-028 mem_ready outside ACCESS has no effect.
REQ-029 Back-to-back accesses: mio_en held high is accepted again in the IDLE cycle after DONE, so at most one access completes every 3 cycles.

Reset
REQ-030 Asserting reset_n=0 forces IDLE immediately, asynchronously, even mid-access.
REQ-031 Reset values: MAR=0x0000, MDR=0x0000, latched r_w=0, mem_en=0, mem_we=0, busy=0, done=0, err=0, wait counter=0.
REQ-032 After reset_n deasserts, no access starts until a new mio_en arrives in IDLE.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN: when defined, an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
REQ-034 With MEM_TIMEOUT_EN defined, WAIT_MAX consecutive ACCESS cycles without mem_ready move the FSM to DONE with MDR unchanged and err set.
REQ-035 With MEM_TIMEOUT_EN defined, err is sticky until the next accepted mio_en or reset; mem_ready arriving in the same cycle as the timeout takes priority, and the access completes normally.
REQ-036 Without MEM_TIMEOUT_EN, the err port and counter are absent and ACCESS waits indefinitely for mem_ready.

Verification
REQ-037 Read: ld_mar=1 with mar_in=0x3000, then mio_en=1 r_w=0, with mem_ready=1 and mem_rdata=0xBEEF on the first ACCESS cycle -> mem_addr=0x3000, mem_we=0, done pulses once, mdr_out=0xBEEF.
REQ-038 Write: ld_mar, ld_mdr and mio_en in the same cycle with mar_in=0xFE00, mdr_in=0x1234, r_w=1 -> next cycle mem_en=1, mem_we=1, mem_addr=0xFE00, mem_wdata=0x1234; MDR unchanged after done.
REQ-039 Wait states: mem_ready held low for 5 cycles -> mem_en held high for 6 cycles, ld_mar with 0x0001 is ignored during the access, and done rises one cycle after mem_ready.
REQ-040 Reset mid-access: reset_n pulsed low during ACCESS -> mem_en=0 immediately, MAR=MDR=0x0000, and no done pulse occurs.
REQ-041 Timeout (MEM_TIMEOUT_EN, WAIT_MAX=4): mem_ready never asserted -> DONE after 4 ACCESS cycles with err=1 and MDR unchanged; err clears on the next mio_en.
REQ-042 Back-to-back: mio_en held high for 9 cycles with mem_ready=1 -> exactly 3 done pulses, spaced 3 cycles apart.
